// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared formats, RV32I opcodes, field widths and immediate-fit helper
package instr_encoder_pkg;

   localparam int INSTR_W = 32;
   localparam int OPC_W   = 7;
   localparam int REG_W   = 5;
   localparam int F3_W    = 3;
   localparam int F7_W    = 7;
   localparam int FMT_W   = 3;

   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_fmt_e;

   localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP     = 7'b0110011;

   // True when imm[31:msb] are all equal, i.e. the value is a sign extension from bit msb
   function automatic logic sext_fits(input logic [INSTR_W-1:0] imm, input int unsigned msb);
      logic [INSTR_W-1:0] s;
      s = INSTR_W'($signed(imm) >>> msb);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: combinational RV32I field packer with optional immediate representability check
module instr_field_pack
   import instr_encoder_pkg::*;
#(
   parameter bit RANGE_CHECK = 1'b0
) (
   input  logic [FMT_W-1:0]   fmt,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [REG_W-1:0]   rd,
   input  logic [REG_W-1:0]   rs1,
   input  logic [REG_W-1:0]   rs2,
   input  logic [F3_W-1:0]    funct3,
   input  logic [F7_W-1:0]    funct7,
   input  logic [INSTR_W-1:0] imm,
   output logic [INSTR_W-1:0] instr,
   output logic               err
);

   logic illegal;
   logic rng_err;

   assign illegal = fmt > FMT_J;

   // Scatter fields into the format's layout; illegal formats pack an all-zero word
   always_comb begin
      instr = '0;
      case (fmt)
         FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U:   instr = {imm[31:12], rd, opcode};
         FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: instr = '0;
      endcase
   end

   generate
      if (RANGE_CHECK) begin : g_rng
         // Flag immediates whose dropped bits would change the decoded value
         always_comb begin
            rng_err = 1'b0;
            case (fmt)
               FMT_I, FMT_S: rng_err = !sext_fits(imm, 11);
               FMT_B:        rng_err = !sext_fits(imm, 12) | imm[0];
               FMT_U:        rng_err = |imm[11:0];
               FMT_J:        rng_err = !sext_fits(imm, 20) | imm[0];
               default:      rng_err = 1'b0;
            endcase
         end
      end else begin : g_no_rng
         assign rng_err = 1'b0;
      end
   endgenerate

   assign err = illegal | rng_err;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: pipelined RV32I instruction encoder with valid/ready on both sides; IMM_RANGE_CHECK_EN enables immediate range errors
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FMT_W-1:0]     in_fmt,
   input  logic [OPC_W-1:0]     in_opcode,
   input  logic [REG_W-1:0]     in_rd,
   input  logic [REG_W-1:0]     in_rs1,
   input  logic [REG_W-1:0]     in_rs2,
   input  logic [F3_W-1:0]      in_funct3,
   input  logic [F7_W-1:0]      in_funct7,
   input  logic [INSTR_W-1:0]   in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   out_instr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

`ifdef IMM_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   logic [INSTR_W-1:0] pack_instr;
   logic               pack_err;
   logic               in_hs;

   instr_field_pack #(.RANGE_CHECK(RANGE_CHECK)) u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .instr  (pack_instr),
      .err    (pack_err)
   );

   assign in_ready = !out_valid | out_ready;
   assign in_hs    = in_valid & in_ready;

   // Output stage: load on input handshake, drop valid on drain, hold while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
      end else begin
         if (in_ready) out_valid <= in_valid;
         if (in_hs) begin
            out_instr <= pack_instr;
            out_err   <= pack_err;
         end
      end
   end

   // Saturating count of accepted requests that carry an error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_count <= '0;
      else if (in_hs && pack_err && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Pipelined RISC-V RV32I instruction encoder: the inverse of the core's immediate decode path.
- Accepts a format tag, register and function fields, and a full 32-bit immediate, and emits the packed 32-bit instruction word.
- Sits in the debug/injection path: the debug module and the test-program loader use it to build instructions fed to fetch.
- Handshake on both sides, one registered output stage, full throughput, optional immediate range checking.

## Interface

Parameters:
- ERR_CNT_W, default 16: width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6–7 illegal.
- in_opcode  in  7  opcode field, bits [6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; R format only.
- in_imm  in  32  sign-extended byte-offset immediate, as the decoder would produce it.
- out_valid  out  1  packed instruction valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  packed instruction.
- out_err  out  1  request was illegal or unrepresentable; qualified by out_valid.
- err_count  out  ERR_CNT_W  saturating count of accepted requests with err set.

## Operation

- Packing, with opcode always in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Unused fields for a format are ignored. R ignores in_imm.
- Illegal format (6 or 7) packs 32'h0 with err=1, regardless of the macro.
- Representability rules, used only when the range check is enabled:
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Unrepresentable immediates are still packed using the truncated bits above.
- err_count increments on each input handshake whose err is 1. It saturates at all-ones.

## Timing

- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is combinational; there is no bubble on a simultaneous drain and fill.
- Latency is 1 cycle: request accepted at edge N appears at out_valid after edge N, with out_instr/out_err registered.
- While out_valid=1 and out_ready=0: out_instr, out_err and out_valid are held stable and in_ready=0.
- Output handshake with no input handshake in the same cycle: out_valid falls next cycle.
- Output and input handshakes in the same cycle: the new word replaces the old one and out_valid stays 1.
- Reset values: out_valid=0, out_instr=32'h0, out_err=0, err_count=0.
- Reset is asserted asynchronously. A held word is discarded; nothing is replayed.
- Upstream must not drop in_valid before its handshake. The encoder does not check this.

## Configuration

- IMM_RANGE_CHECK_EN defined: the representability rules drive err. Illegal formats also set err.
- IMM_RANGE_CHECK_EN undefined: only an illegal format sets err. Immediates are silently truncated per the packing rules, and the range-check logic is absent.

## Structure

- The shared package (alongside types.sv) holds:
  - instr_fmt_e enum (R, I, S, B, U, J).
  - RV32I opcode constants: OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP.
  - Field width localparams.
- One combinational sub-module, instr_field_pack: fmt and fields in, instr and err out, with the range check inside.
- The top level holds the handshake register, the error counter and the macro-gated wiring.

## Test plan

- I format:
  - opcode 0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF -> out_instr 32'hFFF00093, err=0, one cycle later.
  - imm=32'h800 -> err=1 and err_count=1 with the macro; err=0 without it; out_instr 32'h80000093 in both.
- U format: opcode 0110111, rd=5, imm=32'h12345000 -> 32'h123452B7, err=0.
- B format: opcode 1100011, rs1=rs2=0, funct3=0, imm=32'hFFFFFFFC -> 32'hFE000EE3. With imm=32'h3 and the macro defined -> err=1.
- J format: opcode 1101111, rd=1, imm=32'h800 -> 32'h001000EF.
- Backpressure:
  - Present 4 back-to-back requests with out_ready=0 for 3 cycles at word 2 -> out_instr stable and in_ready=0 during the stall.
  - All 4 words emerge in order, and throughput returns to 1/cycle after the stall.
- Reset mid-stall: assert rst_n=0 while out_valid=1 -> out_valid, out_err and err_count are 0 immediately (asynchronous), and in_ready=1 after release.
